maze_explorer: RTL and testbench

Controller stage directly upstream of `maze_memory`. It drives the memory's `rd`/`wr`/`x_pos`/`y_pos`/`data_in` and consumes `data_out` to solve the 16x16 maze by depth-first search. It starts at (0,0), marks each visited cell as blocked by writing 1, and backtracks using an internal direction stack. It reports `done` when the target cell is reached, or `fail` when the search is exhausted.

---
 rtl/maze_explorer.sv | 256 +++++++++++++++++++++++++
 tb/tb_maze_explorer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_explorer.sv
// Depth-first maze solver that drives a 16x16 single-bit maze memory, marking visited cells.
// Optional path readout of the direction stack in DONE is enabled by defining MAZE_PATH_READOUT_EN.
module maze_explorer #(
    parameter logic [3:0] TGT_X       = 4'd15,
    parameter logic [3:0] TGT_Y       = 4'd15,
    parameter int         STACK_DEPTH = 256
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_mem_rd,
    output logic       o_mem_wr,
    output logic [3:0] o_mem_x,
    output logic [3:0] o_mem_y,
    output logic       o_mem_din,
    input  logic       i_mem_dout,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fail,
    output logic [3:0] o_cur_x,
    output logic [3:0] o_cur_y,
    output logic [8:0] o_path_len,
    input  logic       i_path_rd,
    output logic       o_path_valid,
    output logic [1:0] o_path_dir,
    output logic       o_path_last
);

    localparam int AW = $clog2(STACK_DEPTH);

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_PICK,
        S_RD,
        S_CHK,
        S_BACK,
        S_DONE,
        S_FAIL
    } state_t;

    state_t     r_state, w_state_nx;
    logic [3:0] r_cur_x, r_cur_y, w_cur_x_nx, w_cur_y_nx;
    logic [3:0] r_nb_x,  r_nb_y,  w_nb_x_nx,  w_nb_y_nx;
    logic [2:0] r_dir,   w_dir_nx;
    logic [8:0] r_sp,    w_sp_nx;
    logic       w_push;

    logic [1:0] r_stack [STACK_DEPTH];

    // Neighbour of cur in the direction under test, and whether it falls off the grid.
    logic [3:0] w_nb_x, w_nb_y;
    logic       w_oob;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_nb_x = r_cur_x;
        w_nb_y = r_cur_y;
        w_oob  = 1'b0;
        case (r_dir[1:0])
            DIR_N: begin
                w_oob  = (r_cur_y == 4'd0);
                w_nb_y = r_cur_y - 4'd1;
            end
            DIR_E: begin
                w_oob  = (r_cur_x == 4'd15);
                w_nb_x = r_cur_x + 4'd1;
            end
            DIR_S: begin
                w_oob  = (r_cur_y == 4'd15);
                w_nb_y = r_cur_y + 4'd1;
            end
            default: begin
                w_oob  = (r_cur_x == 4'd0);
                w_nb_x = r_cur_x - 4'd1;
            end
        endcase
    end

    // Backtrack target: undo the move recorded on top of the stack.
    logic [8:0] w_sp_dec;
    logic [1:0] w_pop_dir;
    logic [3:0] w_back_x, w_back_y;

    assign w_sp_dec  = r_sp - 9'd1;
    assign w_pop_dir = r_stack[w_sp_dec[AW-1:0]];

    always_comb begin
        w_back_x = r_cur_x;
        w_back_y = r_cur_y;
        case (w_pop_dir)
            DIR_N:   w_back_y = r_cur_y + 4'd1;
            DIR_E:   w_back_x = r_cur_x - 4'd1;
            DIR_S:   w_back_y = r_cur_y - 4'd1;
            default: w_back_x = r_cur_x + 4'd1;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_cur_x_nx = r_cur_x;
        w_cur_y_nx = r_cur_y;
        w_nb_x_nx  = r_nb_x;
        w_nb_y_nx  = r_nb_y;
        w_dir_nx   = r_dir;
        w_sp_nx    = r_sp;
        w_push     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (i_start) begin
                    w_state_nx = S_MARK;
                    w_cur_x_nx = 4'd0;
                    w_cur_y_nx = 4'd0;
                    w_dir_nx   = 3'd0;
                    w_sp_nx    = 9'd0;
                end
            end
            S_MARK: begin
                w_state_nx = (r_cur_x == TGT_X && r_cur_y == TGT_Y) ? S_DONE : S_PICK;
            end
            S_PICK: begin
                if (r_dir == 3'd4) begin
                    w_state_nx = S_BACK;
                end else if (w_oob) begin
                    w_dir_nx = r_dir + 3'd1;
                end else begin
                    w_nb_x_nx  = w_nb_x;
                    w_nb_y_nx  = w_nb_y;
                    w_state_nx = S_RD;
                end
            end
            S_RD: begin
                w_state_nx = S_CHK;
            end
            S_CHK: begin
                if (!i_mem_dout) begin
                    w_push     = 1'b1;
                    w_sp_nx    = r_sp + 9'd1;
                    w_cur_x_nx = r_nb_x;
                    w_cur_y_nx = r_nb_y;
                    w_dir_nx   = 3'd0;
                    w_state_nx = S_MARK;
                end else begin
                    w_dir_nx   = r_dir + 3'd1;
                    w_state_nx = S_PICK;
                end
            end
            S_BACK: begin
                if (r_sp == 9'd0) begin
                    w_state_nx = S_FAIL;
                end else begin
                    w_sp_nx    = w_sp_dec;
                    w_cur_x_nx = w_back_x;
                    w_cur_y_nx = w_back_y;
                    w_dir_nx   = {1'b0, w_pop_dir} + 3'd1;
                    w_state_nx = S_PICK;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cur_x <= 4'd0;
            r_cur_y <= 4'd0;
            r_nb_x  <= 4'd0;
            r_nb_y  <= 4'd0;
            r_dir   <= 3'd0;
            r_sp    <= 9'd0;
        end else begin
            r_state <= w_state_nx;
            r_cur_x <= w_cur_x_nx;
            r_cur_y <= w_cur_y_nx;
            r_nb_x  <= w_nb_x_nx;
            r_nb_y  <= w_nb_y_nx;
            r_dir   <= w_dir_nx;
            r_sp    <= w_sp_nx;
        end
    end

    // NOTE: the stack array is not reset; entries above sp are never read, so their contents are don't-care.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_stack[r_sp[AW-1:0]] <= r_dir[1:0];
        end
    end

    assign o_mem_rd   = (r_state == S_RD);
    assign o_mem_wr   = (r_state == S_MARK);
    assign o_mem_x    = o_mem_rd ? r_nb_x : r_cur_x;
    assign o_mem_y    = o_mem_rd ? r_nb_y : r_cur_y;
    assign o_mem_din  = 1'b1;
    assign o_busy     = (r_state == S_MARK) || (r_state == S_PICK) || (r_state == S_RD) ||
                        (r_state == S_CHK)  || (r_state == S_BACK);
    assign o_done     = (r_state == S_DONE);
    assign o_fail     = (r_state == S_FAIL);
    assign o_cur_x    = r_cur_x;
    assign o_cur_y    = r_cur_y;
    assign o_path_len = r_sp;

`ifdef MAZE_PATH_READOUT_EN
    logic       w_start_acc;
    logic       w_rd_fire;
    logic       w_rd_is_last;
    logic [8:0] r_rd_idx;
    logic       r_rd_end;
    logic       r_path_valid;
    logic [1:0] r_path_dir;
    logic       r_path_last;

    assign w_start_acc  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL));
    assign w_rd_fire    = (r_state == S_DONE) && i_path_rd && !r_rd_end && (r_sp != 9'd0);
    assign w_rd_is_last = (r_rd_idx == w_sp_dec);

    // Entries stream bottom-first; once the last one is sent, further requests wait for a new start.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_acc) begin
            r_rd_idx     <= 9'd0;
            r_rd_end     <= 1'b0;
            r_path_valid <= 1'b0;
            r_path_dir   <= 2'd0;
            r_path_last  <= 1'b0;
        end else begin
            r_path_valid <= w_rd_fire;
            r_path_dir   <= w_rd_fire ? r_stack[r_rd_idx[AW-1:0]] : 2'd0;
            r_path_last  <= w_rd_fire && w_rd_is_last;
            if (w_rd_fire) begin
                r_rd_idx <= r_rd_idx + 9'd1;
                if (w_rd_is_last) begin
                    r_rd_end <= 1'b1;
                end
            end
        end
    end

    assign o_path_valid = r_path_valid;
    assign o_path_dir   = r_path_dir;
    assign o_path_last  = r_path_last;
`else
    logic w_unused_path_rd;

    assign w_unused_path_rd = i_path_rd;
    assign o_path_valid     = 1'b0;
    assign o_path_dir       = 2'd0;
    assign o_path_last      = 1'b0;
`endif

endmodule

// File: tb/tb_maze_explorer.sv
// Self-checking bench for maze_explorer: a maze memory, a queue-based DFS reference model,
// a per-cycle compare process, and directed scenarios with hand-computed literal expectations.
module tb_maze_explorer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mem_rd, mem_wr, mem_din, mem_dout;
    logic [3:0] mem_x, mem_y;
    logic       busy, done, fail;
    logic [3:0] cur_x, cur_y;
    logic [8:0] path_len;
    logic       path_rd, path_valid, path_last;
    logic [1:0] path_dir;

    logic       start0;
    logic       mem_rd0, mem_wr0, mem_din0;
    logic [3:0] mem_x0, mem_y0;
    logic       busy0, done0, fail0;
    logic [3:0] cur_x0, cur_y0;
    logic [8:0] path_len0;
    logic       path_valid0, path_last0;
    logic [1:0] path_dir0;
    logic       mem_dout0;
    logic       path_rd0;

    int n_total = 0;
    int n_pass  = 0;

    maze_explorer u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_mem_rd    (mem_rd),
        .o_mem_wr    (mem_wr),
        .o_mem_x     (mem_x),
        .o_mem_y     (mem_y),
        .o_mem_din   (mem_din),
        .i_mem_dout  (mem_dout),
        .o_busy      (busy),
        .o_done      (done),
        .o_fail      (fail),
        .o_cur_x     (cur_x),
        .o_cur_y     (cur_y),
        .o_path_len  (path_len),
        .i_path_rd   (path_rd),
        .o_path_valid(path_valid),
        .o_path_dir  (path_dir),
        .o_path_last (path_last)
    );

    maze_explorer #(.TGT_X(4'd0), .TGT_Y(4'd0)) u_dut0 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start0),
        .o_mem_rd    (mem_rd0),
        .o_mem_wr    (mem_wr0),
        .o_mem_x     (mem_x0),
        .o_mem_y     (mem_y0),
        .o_mem_din   (mem_din0),
        .i_mem_dout  (mem_dout0),
        .o_busy      (busy0),
        .o_done      (done0),
        .o_fail      (fail0),
        .o_cur_x     (cur_x0),
        .o_cur_y     (cur_y0),
        .o_path_len  (path_len0),
        .i_path_rd   (path_rd0),
        .o_path_valid(path_valid0),
        .o_path_dir  (path_dir0),
        .o_path_last (path_last0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Maze memory: bit x of row y; 1 = wall or visited. One-cycle read latency.
    logic [15:0] load_img [16];
    logic [15:0] mem      [16];
    logic        load_req;

    always @(posedge clk) begin
        if (load_req) mem <= load_img;
        else if (mem_wr) mem[mem_y][mem_x] <= 1'b1;
        if (mem_rd) mem_dout <= mem[mem_y][mem_x];
    end

    // Reference model: plain DFS over a copy of the maze, producing the expected access
    // sequence, final path, outcome and busy-cycle cost from the per-step cost rules.
    logic [15:0] m_maze [16];
    logic [8:0]  exp_acc  [$];
    logic [1:0]  exp_path [$];
    int          exp_cost;
    bit          exp_done;
    int          exp_cx, exp_cy;

    function automatic int dx(input int d);
        return (d == 1) ? 1 : (d == 3) ? -1 : 0;
    endfunction

    function automatic int dy(input int d);
        return (d == 0) ? -1 : (d == 2) ? 1 : 0;
    endfunction

    task automatic model_run(input int tx, input int ty);
        int  cx, cy, d, nx, ny, p;
        bit  fin, moved, need_mark;
        cx = 0; cy = 0; d = 0;
        fin = 0; need_mark = 1;
        exp_acc.delete();
        exp_path.delete();
        exp_cost = 0;
        exp_done = 0;
        while (!fin) begin
            if (need_mark) begin
                exp_cost++;
                exp_acc.push_back({1'b1, 4'(cx), 4'(cy)});
                m_maze[cy][cx] = 1'b1;
                need_mark = 0;
                d = 0;
                if (cx == tx && cy == ty) begin
                    exp_done = 1;
                    fin = 1;
                end
            end
            if (!fin) begin
                moved = 0;
                while (d < 4 && !moved) begin
                    exp_cost++;
                    nx = cx + dx(d);
                    ny = cy + dy(d);
                    if (nx >= 0 && nx <= 15 && ny >= 0 && ny <= 15) begin
                        exp_cost += 2;
                        exp_acc.push_back({1'b0, 4'(nx), 4'(ny)});
                        if (!m_maze[ny][nx]) begin
                            exp_path.push_back(2'(d));
                            cx = nx; cy = ny;
                            moved = 1;
                            need_mark = 1;
                        end
                    end
                    if (!moved) d++;
                end
                if (!moved) begin
                    exp_cost += 2;
                    if (exp_path.size() == 0) begin
                        fin = 1;
                    end else begin
                        p  = int'(exp_path.pop_back());
                        cx = cx - dx(p);
                        cy = cy - dy(p);
                        d  = p + 1;
                    end
                end
            end
        end
        exp_cx = cx;
        exp_cy = cy;
    endtask

    // Per-cycle compare: strobe exclusivity, constant data, idle address, access order.
    bit chk_en  = 0;
    int cyc_cnt = 0;
    int acc_cnt = 0;
    int wr0_cnt = 0;
    int rd0_cnt = 0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (chk_en && busy) begin
            cyc_cnt++;
            check("strobe_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
            check("mem_din", {31'd0, mem_din}, 32'd1);
            if (mem_rd || mem_wr) begin
                acc_cnt++;
                if (exp_acc.size() != 0) e = {23'd0, exp_acc.pop_front()};
                else e = 32'hdead;
                check("mem_access", {23'd0, mem_wr, mem_x, mem_y}, e);
            end else begin
                check("idle_addr", {24'd0, mem_x, mem_y}, {24'd0, cur_x, cur_y});
            end
        end
        if (mem_wr0 && mem_x0 == 4'd0 && mem_y0 == 4'd0) wr0_cnt++;
        if (mem_rd0) rd0_cnt++;
    end

    task automatic apply_maze();
        for (int y = 0; y < 16; y++) m_maze[y] = load_img[y];
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
    endtask

    task automatic pulse_start();
        cyc_cnt = 0;
        acc_cnt = 0;
        chk_en  = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_flag(input string tag);
        int i;
        for (i = 0; i < 5000 && !(done || fail); i++) @(negedge clk);
        check({tag, "_no_timeout"}, {31'd0, (i < 5000)}, 32'd1);
    endtask

    task automatic check_outcome(input string tag);
        check({tag, "_done"},   {31'd0, done}, {31'd0, exp_done});
        check({tag, "_fail"},   {31'd0, fail}, {31'd0, !exp_done});
        check({tag, "_busy"},   {31'd0, busy}, 32'd0);
        check({tag, "_len"},    {23'd0, path_len}, exp_path.size());
        check({tag, "_cur"},    {24'd0, cur_x, cur_y}, {24'd0, 4'(exp_cx), 4'(exp_cy)});
        check({tag, "_cycles"}, cyc_cnt, exp_cost);
        check({tag, "_acc_left"}, exp_acc.size(), 32'd0);
    endtask

    logic [1:0] got_dir  [$];
    logic       got_last [$];

    task automatic do_readout(input string tag);
        int n;
        int rev;
        n = exp_path.size();
        got_dir.delete();
        got_last.delete();
        path_rd = 1'b1;
        for (int i = 0; i < n + 4; i++) begin
            @(negedge clk);
            if (path_valid) begin
                got_dir.push_back(path_dir);
                got_last.push_back(path_last);
            end
            if (i >= n + 2) path_rd = 1'b0;
        end
        path_rd = 1'b0;
        check({tag, "_flag_held"}, {31'd0, done}, {31'd0, exp_done});
`ifdef MAZE_PATH_READOUT_EN
        check({tag, "_rd_count"}, got_dir.size(), n);
        rev = 0;
        for (int i = 0; i < got_dir.size() && i < n; i++) begin
            check({tag, "_rd_dir"},  {30'd0, got_dir[i]}, {30'd0, exp_path[i]});
            check({tag, "_rd_last"}, {31'd0, got_last[i]}, {31'd0, (i == n - 1)});
            if (i > 0 && got_dir[i] == (got_dir[i-1] ^ 2'd2)) rev++;
        end
        check({tag, "_rd_no_reversal"}, rev, 32'd0);
`else
        check({tag, "_rd_tied_off"}, got_dir.size(), 32'd0);
`endif
    endtask

    initial begin
        int rv;
        rst = 1'b1; start = 1'b0; start0 = 1'b0; path_rd = 1'b0; path_rd0 = 1'b0;
        load_req = 1'b0; mem_dout = 1'b0; mem_dout0 = 1'b0;
        for (int y = 0; y < 16; y++) load_img[y] = 16'h0000;
        repeat (3) @(negedge clk);

        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_flags", {30'd0, done, fail}, 32'd0);
        check("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        check("rst_din",   {31'd0, mem_din}, 32'd1);
        check("rst_cur",   {24'd0, cur_x, cur_y}, 32'd0);
        check("rst_len",   {23'd0, path_len}, 32'd0);
        check("rst_path_out", {28'd0, path_valid, path_dir, path_last}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // A: empty maze, straight east then south to (15,15).
        for (int y = 0; y < 16; y++) load_img[y] = 16'h0000;
        apply_maze();
        model_run(15, 15);
        check("pinA_cost", exp_cost, 32'd194);
        check("pinA_len",  exp_path.size(), 32'd30);
        check("pinA_acc",  exp_acc.size(), 32'd75);
        check("pinA_turn", {28'd0, exp_path[14], exp_path[15]}, {28'd0, 2'd1, 2'd2});
        pulse_start();
        wait_flag("A");
        check_outcome("A");
        check("A_len_lit", {23'd0, path_len}, 32'd30);
        do_readout("A");

        // B: both exits of (0,0) walled; search fails after touching three cells.
        for (int y = 0; y < 16; y++) load_img[y] = 16'h0000;
        load_img[0] = 16'h0002;
        load_img[1] = 16'h0001;
        apply_maze();
        model_run(15, 15);
        check("pinB_cost", exp_cost, 32'd11);
        check("pinB_acc",  exp_acc.size(), 32'd3);
        pulse_start();
        wait_flag("B");
        check_outcome("B");
        check("B_fail_lit", {30'd0, fail, done}, 32'd2);
        check("B_acc_cnt", acc_cnt, 32'd3);
        do_readout("B");

        // C: dead end at (15,0) forces a backtrack, then column 14 leads down.
        load_img[0] = 16'h0000;
        load_img[1] = 16'h8000;
        for (int y = 2; y < 15; y++) load_img[y] = 16'hbfff;
        load_img[15] = 16'h3fff;
        apply_maze();
        model_run(15, 15);
        check("pinC_len",  exp_path.size(), 32'd30);
        check("pinC_done", {31'd0, exp_done}, 32'd1);
        pulse_start();
        wait_flag("C");
        check_outcome("C");
        do_readout("C");

        // D: target at the origin on the second instance.
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        check("D_busy_first", {30'd0, busy0, done0}, 32'd2);
        check("D_wr_first", {23'd0, mem_wr0, mem_x0, mem_y0}, {23'd0, 1'b1, 8'h00});
        @(negedge clk);
        check("D_done", {30'd0, done0, busy0}, 32'd2);
        check("D_len", {23'd0, path_len0}, 32'd0);
        @(negedge clk);
        check("D_wr_count", wr0_cnt, 32'd1);
        check("D_rd_count", rd0_cnt, 32'd0);

        // E: reset 20 cycles into a search.
        for (int y = 0; y < 16; y++) load_img[y] = 16'h0000;
        apply_maze();
        model_run(15, 15);
        pulse_start();
        repeat (20) @(negedge clk);
        check("E_busy_before", {31'd0, busy}, 32'd1);
        chk_en = 0;
        rst = 1'b1;
        @(negedge clk);
        check("E_rst_busy",  {31'd0, busy}, 32'd0);
        check("E_rst_flags", {30'd0, done, fail}, 32'd0);
        check("E_rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        check("E_rst_din",   {31'd0, mem_din}, 32'd1);
        check("E_rst_cur",   {24'd0, cur_x, cur_y}, 32'd0);
        check("E_rst_len",   {23'd0, path_len}, 32'd0);
        check("E_rst_path_out", {28'd0, path_valid, path_dir, path_last}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // F: start re-pulsed during the search must not disturb it.
        apply_maze();
        model_run(15, 15);
        pulse_start();
        rv = 0;
        for (int i = 0; i < 5000 && !(done || fail); i++) begin
            @(negedge clk);
            start = (i == 3 || i == 40 || i == 150);
            rv = i;
        end
        start = 1'b0;
        check("F_no_timeout", {31'd0, (rv < 4999)}, 32'd1);
        check_outcome("F");
        check("F_cycles_lit", cyc_cnt, 32'd194);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
